// File: rtl/serial_bit_feeder_pkg.sv
// Shared definitions for the serial feeder and the serial sequence detectors.
// Holds the 1-bit state encoding and the default word width / idle fill level
// so that the feeder and the detector benches agree on them.
package serial_bit_feeder_pkg;

  // Feeder FSM states: idle (no word on the line) or shifting a word out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Default bits per word.
  localparam int unsigned DEF_WIDTH = 8;

  // Default level driven on the serial line between words.
  localparam logic DEF_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_feeder_shift_reg.sv
// serial_shift_reg: parallel-load shift register that presents one bit per
// shift, in either bit order.
// Ports:
//   clk     in  1      clock, posedge
//   reset   in  1      asynchronous, active-high; register fills with FILL_BIT
//   load_i  in  1      capture data_i (takes priority over shift_i)
//   shift_i in  1      advance to the next bit, back-filling with FILL_BIT
//   data_i  in  WIDTH  word to capture
//   bit_o   out 1      bit currently presented; taken straight from a flop
// The presented bit is always the head of the register (MSB or LSB depending on
// MSB_FIRST), so loading an all-FILL_BIT word puts the idle level on bit_o.
module serial_shift_reg
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        FILL_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next register contents: load wins over shift; shifting moves the next bit to the head.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], FILL_BIT};
      end else begin
        sr_d = {FILL_BIT, sr_q[WIDTH-1:1]};
      end
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= {WIDTH{FILL_BIT}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: accepts parallel words over valid/ready and drives them
// out one bit per clock to a serial sequence detector. A one-word holding
// register lets consecutive words stream with no idle cycle between them.
// Ports:
//   clk        in  1      clock, posedge
//   reset      in  1      asynchronous, active-high
//   din        in  WIDTH  parallel word
//   din_valid  in  1      din carries a word
//   din_ready  out 1      a word can be accepted this cycle (= hold register empty)
//   ser_out    out 1      serial bit (registered); IDLE_BIT when no word is shifting
//   ser_valid  out 1      ser_out carries a data bit
//   word_done  out 1      pulses with the last bit of each word
//   busy       out 1      a word is shifting or waiting in the hold register
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   PRE_LAST  = CW'(WIDTH - 2);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{IDLE_BIT}};

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;

  logic             xfer_s;
  logic             sh_load_s;
  logic             sh_shift_s;
  logic [WIDTH-1:0] sh_data_s;
  logic             sh_bit_s;

  // Ready depends only on registered state, never on din_valid.
  assign din_ready = !hold_full_q;
  assign xfer_s    = din_valid && din_ready;

  serial_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FILL_BIT  (IDLE_BIT)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sh_load_s),
    .shift_i (sh_shift_s),
    .data_i  (sh_data_s),
    .bit_o   (sh_bit_s)
  );

  // Next-state logic: FSM, bit counter, hold register and shifter control.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ser_valid_d = ser_valid_q;
    word_done_d = 1'b0;
    sh_load_s   = 1'b0;
    sh_shift_s  = 1'b0;
    sh_data_s   = din;
    case (state_q)
      ST_IDLE: begin
        // The hold register is always empty here, so a word goes straight to the shifter.
        if (xfer_s) begin
          sh_load_s   = 1'b1;
          state_d     = ST_SHIFT;
          bit_cnt_d   = CNT_ZERO;
          ser_valid_d = 1'b1;
        end else begin
          ser_valid_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != LAST_CNT) begin
          sh_shift_s  = 1'b1;
          bit_cnt_d   = bit_cnt_q + CW'(1);
          // Flag the cycle that will carry the final bit.
          word_done_d = (bit_cnt_q == PRE_LAST);
          if (xfer_s) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end else begin
            hold_d = hold_q;
          end
        end else if (hold_full_q) begin
          // Held word follows immediately; ready is low so no new transfer can collide.
          sh_load_s   = 1'b1;
          sh_data_s   = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = CNT_ZERO;
        end else if (xfer_s) begin
          // Word offered on the last-bit cycle bypasses the hold register.
          sh_load_s = 1'b1;
          sh_data_s = din;
          bit_cnt_d = CNT_ZERO;
        end else begin
          // Nothing queued: refill with idle level so ser_out drops to IDLE_BIT.
          sh_load_s   = 1'b1;
          sh_data_s   = FILL_WORD;
          state_d     = ST_IDLE;
          ser_valid_d = 1'b0;
          bit_cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bit_cnt_d   = CNT_ZERO;
        hold_full_d = 1'b0;
        ser_valid_d = 1'b0;
        sh_load_s   = 1'b1;
        sh_data_s   = FILL_WORD;
      end
    endcase
    busy_d = (state_d == ST_SHIFT) || hold_full_d;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= CNT_ZERO;
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_out   = sh_bit_s;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

endmodule
